// File: rtl/gates_buf_collect_if.sv
// Stream bundle for the lane collector: a narrow beat stream in, a wide word stream out.
// The master side belongs to whoever produces beats and consumes words.
interface gates_buf_collect_if #(
    parameter int WORD_W = 128,
    parameter int LANE_W = 8
);
    localparam int NBEATS = WORD_W / LANE_W;
    localparam int CNT_W  = $clog2(NBEATS) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [LANE_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/gates_buf_collect.sv
// Packs narrow lane beats into one wide word, lane 0 at the LSB.
// A word closes when its last lane fills or when flush closes a non-empty word.
// If the output register is still occupied the closed word waits in the
// assembly register (PENDING) and the input stalls until the consumer frees it.
// WORD_W must be an exact multiple of LANE_W.
module gates_buf_collect #(
    parameter int WORD_W = 128,
    parameter int LANE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    gates_buf_collect_if.slave    bus
);
    localparam int NBEATS = WORD_W / LANE_W;
    localparam int CNT_W  = $clog2(NBEATS) + 1;
    localparam int LIDX_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic {
        FILL,
        PENDING
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  asm_q, asm_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               out_valid_q, out_valid_d;
    logic [WORD_W-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;

    logic               accept;
    logic               out_free;
    logic               close_word;
    logic [WORD_W-1:0]  asm_next;
    logic [CNT_W-1:0]   cnt_next;
    logic [LIDX_W-1:0]  lane_idx;

    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

    // Next-state: merge the incoming beat, decide whether the word closes, and route it to the output or hold it.
    always_comb begin
        state_d     = state_q;
        asm_d       = asm_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;

        lane_idx   = idx_q[LIDX_W-1:0];
        accept     = bus.in_valid && (state_q == FILL);
        out_free   = !out_valid_q || bus.out_ready;
        cnt_next   = idx_q + CNT_W'(accept);
        asm_next   = asm_q;
        close_word = 1'b0;

        for (int i = 0; i < NBEATS; i++) begin
            if (accept && (lane_idx == LIDX_W'(i))) begin
                asm_next[i*LANE_W +: LANE_W] = bus.in_data;
            end
        end

        // An accepted word leaves the output empty unless something reloads it below.
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == FILL) begin
            close_word = (accept && (idx_q == CNT_W'(NBEATS - 1))) ||
                         (bus.flush && ((idx_q != '0) || accept));
            if (close_word && out_free) begin
                out_valid_d = 1'b1;
                out_data_d  = asm_next;
                out_count_d = cnt_next;
                asm_d       = '0;
                idx_d       = '0;
            end else if (close_word) begin
                state_d = PENDING;
                asm_d   = asm_next;
                idx_d   = cnt_next;
            end else begin
                asm_d = asm_next;
                idx_d = cnt_next;
            end
        end else begin
            if (bus.out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = asm_q;
                out_count_d = idx_q;
                asm_d       = '0;
                idx_d       = '0;
                state_d     = FILL;
            end
        end
    end

    // State and output registers; reset drops any partial or pending word at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            asm_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end
endmodule

// File: tb/tb_gates_buf_collect.sv
// Bench for the lane collector: directed scenarios followed by random traffic,
// every cycle compared against a beat-queue reference model.
module tb_gates_buf_collect;
    localparam int WORD_W = 128;
    localparam int LANE_W = 8;
    localparam int NBEATS = WORD_W / LANE_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    gates_buf_collect_if #(.WORD_W(WORD_W), .LANE_W(LANE_W)) bus ();

    gates_buf_collect #(.WORD_W(WORD_W), .LANE_W(LANE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Reference model: beats of the open word, plus the output register contents.
    logic [7:0]        m_beats[$];
    bit                m_pending;
    bit                m_ov;
    logic [WORD_W-1:0] m_data;
    int                m_count;

    function automatic logic [WORD_W-1:0] packBeats();
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < m_beats.size(); i++) w[i*8 +: 8] = m_beats[i];
        return w;
    endfunction

    task automatic modelReset();
        m_beats.delete();
        m_pending = 0;
        m_ov      = 0;
        m_data    = '0;
        m_count   = 0;
    endtask

    task automatic modelStep(input bit v, input logic [7:0] d, input bit f, input bit r);
        bit free_slot;
        bit close_now;
        free_slot = !m_ov || r;
        if (m_ov && r) m_ov = 0;
        if (!m_pending) begin
            if (v) m_beats.push_back(d);
            close_now = (m_beats.size() == NBEATS) || (f && m_beats.size() > 0);
            if (close_now && free_slot) begin
                m_ov = 1; m_data = packBeats(); m_count = m_beats.size(); m_beats.delete();
            end else if (close_now) begin
                m_pending = 1;
            end
        end else if (r) begin
            m_ov = 1; m_data = packBeats(); m_count = m_beats.size(); m_beats.delete();
            m_pending = 0;
        end
    endtask

    task automatic checkVal(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares the DUT against the model; data and count only matter while a word is offered.
    task automatic checkOutput(input string tag);
        checkVal({tag, ".in_ready"}, WORD_W'(bus.in_ready), WORD_W'(!m_pending));
        checkVal({tag, ".out_valid"}, WORD_W'(bus.out_valid), WORD_W'(m_ov));
        if (m_ov) begin
            checkVal({tag, ".out_data"}, bus.out_data, m_data);
            checkVal({tag, ".out_count"}, WORD_W'(bus.out_count), WORD_W'(m_count));
        end
    endtask

    // One cycle: drive inputs just after the falling edge, check, then advance model and DUT together.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit f, input bit r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = r;
        checkOutput("cycle");
        modelStep(v, d, f, r);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse checked 1 unit after assertion, well away from any clock edge.
    task automatic pulseReset(input string tag);
        rst = 1'b1;
        #1;
        modelReset();
        checkVal({tag, ".out_valid"}, WORD_W'(bus.out_valid), '0);
        checkVal({tag, ".out_data"}, bus.out_data, '0);
        checkVal({tag, ".out_count"}, WORD_W'(bus.out_count), '0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkVal("reset.out_valid", WORD_W'(bus.out_valid), '0);
        checkVal("reset.out_data", bus.out_data, '0);
        checkVal("reset.out_count", WORD_W'(bus.out_count), '0);
        rst = 1'b0;
        checkVal("reset.in_ready", WORD_W'(bus.in_ready), WORD_W'(1));

        // Full word of ascending beats.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b1);
        checkVal("full.out_valid", WORD_W'(bus.out_valid), WORD_W'(1));
        checkVal("full.out_data", bus.out_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        checkVal("full.out_count", WORD_W'(bus.out_count), WORD_W'(16));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkVal("full.one_cycle", WORD_W'(bus.out_valid), '0);

        // Partial word closed by a lone flush.
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkVal("flush3.out_data", bus.out_data, 128'hA3A2A1);
        checkVal("flush3.out_count", WORD_W'(bus.out_count), WORD_W'(3));

        // Beat and flush together at lane 0, then flushes on an empty word.
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
        checkVal("flush1.out_data", bus.out_data, 128'h55);
        checkVal("flush1.out_count", WORD_W'(bus.out_count), WORD_W'(1));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkVal("flush_empty.out_valid", WORD_W'(bus.out_valid), '0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Backpressure: two full words with the consumer stalled.
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, (i < 16) ? 8'h11 : 8'h22, 1'b0, 1'b0);
        checkVal("pend.in_ready", WORD_W'(bus.in_ready), '0);
        checkVal("pend.held_data", bus.out_data, {16{8'h11}});
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        checkVal("pend.still_held", bus.out_data, {16{8'h11}});
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkVal("pend.second_data", bus.out_data, {16{8'h22}});
        checkVal("pend.second_count", WORD_W'(bus.out_count), WORD_W'(16));
        checkVal("pend.in_ready_back", WORD_W'(bus.in_ready), WORD_W'(1));
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Streaming: 64 beats back to back, four words.
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 8'(i + 8'h40), 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-word, then reset while a word is pending.
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'hC0, 1'b0, 1'b1);
        pulseReset("rst_mid");
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 8'hD0, 1'b0, 1'b0);
        checkVal("rst_pend.in_ready", WORD_W'(bus.in_ready), '0);
        pulseReset("rst_pend");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
        checkVal("clean.out_data", bus.out_data, 128'h3F3E3D3C_3B3A3938_37363534_33323130);
        checkVal("clean.out_count", WORD_W'(bus.out_count), WORD_W'(16));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 2) != 0));
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
